cpu_accel_hub: RTL and testbench
================================

Name: cpu_accel_hub

Overview:
- Connects the single CPU accelerator port (accel_id, accel_can_read/can_write, accel_read_enable/accel_write_enable, accel_read_data/accel_write_data) to NUM_ACCELS accelerator endpoints.
- Routes each CPU transaction by accel_id.
- Buffers CPU writes in a per-channel FIFO and holds one pending read word per channel, so the CPU only sees can_read/can_write backpressure.
- Sits between cpu and the accelerator blocks (plotter, math units) in the top level.

Parameters:
- NUM_ACCELS, 4, number of accelerator channels (1..16).
- ID_WIDTH, 4, width of accel_id; ids >= NUM_ACCELS are unmapped.
- DATA_WIDTH, 16, word width on both sides.
- WR_FIFO_DEPTH, 4, per-channel write FIFO depth (power of two, >= 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- accel_id  in  ID_WIDTH  channel selected by CPU
- accel_can_read  out  1  selected channel has a read word held
- accel_can_write  out  1  selected channel write FIFO not full
- accel_read_enable  in  1  CPU consumes held read word
- accel_read_data  out  DATA_WIDTH  held word of selected channel
- accel_write_enable  in  1  CPU pushes accel_write_data
- accel_write_data  in  DATA_WIDTH  write word
- acc_wr_valid  out  NUM_ACCELS  per-channel FIFO head valid
- acc_wr_data  out  NUM_ACCELS*DATA_WIDTH  per-channel FIFO head, channel i at [i*DW +: DW]
- acc_wr_ready  in  NUM_ACCELS  accelerator accepts head
- acc_rd_valid  in  NUM_ACCELS  accelerator offers result
- acc_rd_data  in  NUM_ACCELS*DATA_WIDTH  result words
- acc_rd_ready  out  NUM_ACCELS  hub can take result
- err_sticky  out  1  protocol violation seen since reset

Behaviour:
- Reset (rst_n low, asynchronous):
  - All FIFOs empty, all holds invalid, err_sticky = 0.
  - Outputs: acc_wr_valid = 0, acc_rd_ready = all 1s, accel_can_read = 0, accel_can_write = 0 for unmapped id, 1 otherwise.
  - Asserting rst_n mid-transfer discards all buffered words.
- CPU-side outputs are combinational from accel_id and registered state:
  - accel_can_write = mapped && !wr_full[accel_id].
  - accel_can_read = mapped && hold_valid[accel_id].
  - accel_read_data = hold_data[accel_id] when can_read, else 0.
- Write path:
  - accel_write_enable && accel_can_write at cycle t pushes into FIFO[accel_id]; the word is visible on acc_wr_valid/acc_wr_data at t+1.
  - Pop when acc_wr_valid[i] && acc_wr_ready[i]. Each FIFO is strict FIFO order.
  - Full FIFO with push and pop in the same cycle: only the pop proceeds, because can_write is 0 while full.
  - Empty FIFO with push: no bypass; the word is valid the next cycle.
  - Pointers wrap modulo WR_FIFO_DEPTH. The count register is one bit wider than the pointers.
- Read path:
  - acc_rd_ready[i] = !hold_valid[i] || (pop of channel i this cycle).
  - acc_rd_valid[i] && acc_rd_ready[i] at t loads the hold; can_read rises at t+1.
  - Simultaneous CPU pop and accelerator refill on the same channel: the new word is loaded, hold stays valid, and there is no bubble.
- Channels are independent; traffic on unselected channels continues draining and filling while the CPU addresses another id.
- Violations set err_sticky at the next clock; it clears only on reset. No state changes for:
  - accel_write_enable while !accel_can_write (word dropped);
  - accel_read_enable while !accel_can_read;
  - any enable with an unmapped accel_id.
- accel_read_enable and accel_write_enable in the same cycle are both legal and act on the same channel.

Decomposition:
- cpu_accel_pkg holds:
  - localparams for default DATA_WIDTH and ID_WIDTH;
  - the typedef accel_word_t (logic [DATA_WIDTH-1:0]);
  - a function for the channel-slice index.
- Sub-module cpu_accel_fifo:
  - parameterised by DATA_WIDTH and DEPTH;
  - ports clk, rst_n, push, push_data, pop, head_valid, head_data, full;
  - instantiated NUM_ACCELS times via generate.
- Read holds and routing are written inline.

Test Plan:
- Reset, then id=2, write 0x1234 with acc_wr_ready[2]=0 → acc_wr_valid[2]=1 and data 0x1234 next cycle; other channels' valid stay 0.
- id=1, 5 back-to-back writes 1..5 with ready=0 → can_write drops after the 4th; the 5th sets err_sticky. Raise ready → 1,2,3,4 drain in order, one per cycle.
- acc_rd_valid[3]=1, data 0xBEEF, id=3 → can_read high one cycle later with read_data 0xBEEF. Read_enable each cycle with continuous valid (0xBEEF, 0xBEF0, 0xBEF1) → can_read stays high and words arrive with no bubble.
- id=7 (unmapped) → can_read=can_write=0; a write_enable sets err_sticky and no channel sees a push.
- Pulse rst_n low asynchronously, mid-cycle, with FIFO 0 holding 3 words and hold 1 valid → outputs clear immediately; after release, acc_wr_valid=0 and can_read=0.
- Same cycle: read_enable and write_enable on id=0 with hold and FIFO both non-empty → one word read, one word pushed, counts consistent.

Source files
------------

// File: rtl/cpu_accel_pkg.sv
// Shared definitions for the CPU accelerator hub: default widths, the word
// type and the helper that locates a channel inside a packed per-channel bus.
package cpu_accel_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ID_WIDTH   = 4;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] accel_word_t;

    // Low bit of channel idx within a bus packed as idx*width.
    function automatic int chan_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/cpu_accel_fifo.sv
// Per-channel write FIFO: registered storage, head visible the cycle after a
// push (no bypass), count one bit wider than the wrapping pointers.
module cpu_accel_fifo
    import cpu_accel_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  push_ok_s, pop_ok_s;

    assign head_valid = (count_q != {(PTR_W+1){1'b0}});
    assign full       = (count_q == (PTR_W+1)'(DEPTH));
    assign head_data  = mem_q[rd_ptr_q];
    assign push_ok_s  = push && !full;
    assign pop_ok_s   = pop && head_valid;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/cpu_accel_hub.sv
// Routes the single CPU accelerator port to NUM_ACCELS channels: a write FIFO
// and a one-word read hold per channel, plus a sticky protocol-error flag.
module cpu_accel_hub
    import cpu_accel_pkg::*;
#(
    parameter int NUM_ACCELS    = 4,
    parameter int ID_WIDTH      = DEFAULT_ID_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ID_WIDTH-1:0]              accel_id,
    output logic                             accel_can_read,
    output logic                             accel_can_write,
    input  logic                             accel_read_enable,
    output logic [DATA_WIDTH-1:0]            accel_read_data,
    input  logic                             accel_write_enable,
    input  logic [DATA_WIDTH-1:0]            accel_write_data,
    output logic [NUM_ACCELS-1:0]            acc_wr_valid,
    output logic [NUM_ACCELS*DATA_WIDTH-1:0] acc_wr_data,
    input  logic [NUM_ACCELS-1:0]            acc_wr_ready,
    input  logic [NUM_ACCELS-1:0]            acc_rd_valid,
    input  logic [NUM_ACCELS*DATA_WIDTH-1:0] acc_rd_data,
    output logic [NUM_ACCELS-1:0]            acc_rd_ready,
    output logic                             err_sticky
);

    logic                  mapped_s;
    logic [NUM_ACCELS-1:0] sel_s, push_s, cpu_pop_s, load_s, wr_full_s;
    logic [NUM_ACCELS-1:0] hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q [NUM_ACCELS];
    logic [DATA_WIDTH-1:0] hold_data_d [NUM_ACCELS];
    logic                  err_q, err_d;

    assign mapped_s   = (32'(accel_id) < 32'(NUM_ACCELS));
    assign err_sticky = err_q;

    // Channel select and CPU-facing view; an unselected channel contributes zeros.
    always_comb begin
        accel_can_write = 1'b0;
        accel_can_read  = 1'b0;
        accel_read_data = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_ACCELS; i++) begin
            sel_s[i]        = mapped_s && (32'(accel_id) == 32'(i));
            accel_can_write = accel_can_write | (sel_s[i] & ~wr_full_s[i]);
            accel_can_read  = accel_can_read | (sel_s[i] & hold_valid_q[i]);
            accel_read_data = accel_read_data
                            | ({DATA_WIDTH{sel_s[i] & hold_valid_q[i]}} & hold_data_q[i]);
            push_s[i]       = sel_s[i] & accel_write_enable & ~wr_full_s[i];
            cpu_pop_s[i]    = sel_s[i] & accel_read_enable & hold_valid_q[i];
            acc_rd_ready[i] = ~hold_valid_q[i] | cpu_pop_s[i];
            load_s[i]       = acc_rd_valid[i] & acc_rd_ready[i];
        end
    end

    // Hold update: a refill wins over a CPU pop so back-to-back reads see no bubble.
    always_comb begin
        for (int i = 0; i < NUM_ACCELS; i++) begin
            hold_valid_d[i] = hold_valid_q[i];
            hold_data_d[i]  = hold_data_q[i];
            if (load_s[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_data_d[i]  = acc_rd_data[chan_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
            end else if (cpu_pop_s[i]) begin
                hold_valid_d[i] = 1'b0;
            end else begin
                hold_valid_d[i] = hold_valid_q[i];
            end
        end
        err_d = err_q
              | (accel_write_enable & ~accel_can_write)
              | (accel_read_enable & ~accel_can_read);
    end

    // Read holds and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= {NUM_ACCELS{1'b0}};
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_ACCELS; i++) begin
                hold_data_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            err_q        <= err_d;
            for (int i = 0; i < NUM_ACCELS; i++) begin
                hold_data_q[i] <= hold_data_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_ACCELS; g++) begin : g_chan
        cpu_accel_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (WR_FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push_s[g]),
            .push_data  (accel_write_data),
            .pop        (acc_wr_ready[g]),
            .head_valid (acc_wr_valid[g]),
            .head_data  (acc_wr_data[chan_lsb(g, DATA_WIDTH) +: DATA_WIDTH]),
            .full       (wr_full_s[g])
        );
    end

endmodule

// File: tb/tb_cpu_accel_hub.sv
// Scoreboard bench for cpu_accel_hub: expected words are queued when driven
// and compared when the accelerator or CPU side handshakes them.
module tb_cpu_accel_hub;
    import cpu_accel_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    accel_id = 4'd0;
    logic          accel_can_read, accel_can_write;
    logic          accel_read_enable = 1'b0;
    logic [DW-1:0] accel_read_data;
    logic          accel_write_enable = 1'b0;
    logic [DW-1:0] accel_write_data = 16'h0000;
    logic [N-1:0]  acc_wr_valid;
    logic [N*DW-1:0] acc_wr_data;
    logic [N-1:0]  acc_wr_ready = 4'b0000;
    logic [N-1:0]  acc_rd_valid = 4'b0000;
    logic [N*DW-1:0] acc_rd_data = 64'h0;
    logic [N-1:0]  acc_rd_ready;
    logic          err_sticky;

    int n_checks = 0;
    int n_errors = 0;
    accel_word_t exp_wr [N][$];
    accel_word_t exp_rd [$];

    cpu_accel_hub u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .accel_id           (accel_id),
        .accel_can_read     (accel_can_read),
        .accel_can_write    (accel_can_write),
        .accel_read_enable  (accel_read_enable),
        .accel_read_data    (accel_read_data),
        .accel_write_enable (accel_write_enable),
        .accel_write_data   (accel_write_data),
        .acc_wr_valid       (acc_wr_valid),
        .acc_wr_data        (acc_wr_data),
        .acc_wr_ready       (acc_wr_ready),
        .acc_rd_valid       (acc_rd_valid),
        .acc_rd_data        (acc_rd_data),
        .acc_rd_ready       (acc_rd_ready),
        .err_sticky         (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every handshake that will complete at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (acc_wr_valid[i] && acc_wr_ready[i]) begin
                    if (exp_wr[i].size() == 0) check_eq("wr_unexpected", 32'(i), 32'hFFFF);
                    else check_eq("wr_data", 32'(acc_wr_data[i*DW +: DW]), 32'(exp_wr[i].pop_front()));
                end
            end
            if (accel_read_enable && accel_can_read) begin
                if (exp_rd.size() == 0) check_eq("rd_unexpected", 32'(accel_read_data), 32'hFFFF);
                else check_eq("rd_data", 32'(accel_read_data), 32'(exp_rd.pop_front()));
            end
        end
    end

    task automatic cpu_write(input logic [3:0] id, input logic [15:0] d, input bit expect_ok);
        accel_id = id;
        accel_write_data = d;
        accel_write_enable = 1'b1;
        if (expect_ok) exp_wr[id].push_back(d);
        tick();
        accel_write_enable = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        check_eq("rst_wr_valid", 32'(acc_wr_valid), 32'h0);
        check_eq("rst_rd_ready", 32'(acc_rd_ready), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rst_can_read", 32'(accel_can_read), 32'h0);
        check_eq("rst_can_write", 32'(accel_can_write), 32'h1);
        check_eq("rst_err", 32'(err_sticky), 32'h0);

        // Single write visible the next cycle on channel 2 only.
        cpu_write(4'd2, 16'h1234, 1'b1);
        check_eq("w1_valid", 32'(acc_wr_valid), 32'h4);
        check_eq("w1_data", 32'(acc_wr_data[2*DW +: DW]), 32'h1234);
        acc_wr_ready[2] = 1'b1;
        tick();
        acc_wr_ready[2] = 1'b0;
        check_eq("w1_drained", 32'(acc_wr_valid[2]), 32'h0);

        // Read hold on channel 3 with continuous refill.
        accel_id = 4'd3;
        acc_rd_valid[3] = 1'b1;
        acc_rd_data[3*DW +: DW] = 16'hBEEF;
        exp_rd.push_back(16'hBEEF);
        tick();
        check_eq("r_can_read", 32'(accel_can_read), 32'h1);
        check_eq("r_data", 32'(accel_read_data), 32'hBEEF);
        check_eq("r_ready_full", 32'(acc_rd_ready), 32'h7);
        acc_rd_data[3*DW +: DW] = 16'hBEF0;
        exp_rd.push_back(16'hBEF0);
        accel_read_enable = 1'b1;
        #1;
        check_eq("r_ready_pop", 32'(acc_rd_ready), 32'hF);
        tick();
        check_eq("r_nobubble1", 32'(accel_can_read), 32'h1);
        acc_rd_data[3*DW +: DW] = 16'hBEF1;
        exp_rd.push_back(16'hBEF1);
        tick();
        check_eq("r_nobubble2", 32'(accel_can_read), 32'h1);
        acc_rd_valid[3] = 1'b0;
        tick();
        accel_read_enable = 1'b0;
        check_eq("r_empty", 32'(accel_can_read), 32'h0);
        check_eq("r_sb_empty", 32'(exp_rd.size()), 32'h0);

        // Simultaneous read and write on channel 0.
        cpu_write(4'd0, 16'h0001, 1'b1);
        cpu_write(4'd0, 16'h0002, 1'b1);
        acc_rd_valid[0] = 1'b1;
        acc_rd_data[0 +: DW] = 16'hA0A0;
        exp_rd.push_back(16'hA0A0);
        tick();
        acc_rd_valid[0] = 1'b0;
        accel_read_enable = 1'b1;
        cpu_write(4'd0, 16'h0003, 1'b1);
        accel_read_enable = 1'b0;
        check_eq("rw_can_read", 32'(accel_can_read), 32'h0);
        check_eq("rw_rd_sb", 32'(exp_rd.size()), 32'h0);
        acc_wr_ready[0] = 1'b1;
        repeat (3) tick();
        acc_wr_ready[0] = 1'b0;
        check_eq("rw_drained", 32'(acc_wr_valid[0]), 32'h0);
        check_eq("rw_wr_sb", 32'(exp_wr[0].size()), 32'h0);
        check_eq("no_err_yet", 32'(err_sticky), 32'h0);

        // Overflow of channel 1 and in-order drain.
        for (int k = 1; k <= 5; k++) begin
            accel_id = 4'd1;
            #1;
            check_eq("ovf_can_write", 32'(accel_can_write), (k <= 4) ? 32'h1 : 32'h0);
            cpu_write(4'd1, 16'(k), k <= 4);
        end
        check_eq("ovf_err", 32'(err_sticky), 32'h1);
        acc_wr_ready[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("ovf_stream", 32'(acc_wr_valid[1]), 32'h1);
            tick();
        end
        acc_wr_ready[1] = 1'b0;
        check_eq("ovf_drained", 32'(acc_wr_valid[1]), 32'h0);
        check_eq("ovf_sb", 32'(exp_wr[1].size()), 32'h0);

        // Asynchronous reset mid-cycle with buffered state.
        for (int k = 0; k < 3; k++) cpu_write(4'd0, 16'(16'h0100 + k), 1'b0);
        acc_rd_valid[1] = 1'b1;
        acc_rd_data[1*DW +: DW] = 16'h5555;
        tick();
        acc_rd_valid[1] = 1'b0;
        accel_id = 4'd1;
        #1;
        check_eq("pre_rst_hold", 32'(accel_can_read), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_wr_valid", 32'(acc_wr_valid), 32'h0);
        check_eq("arst_can_read", 32'(accel_can_read), 32'h0);
        check_eq("arst_err", 32'(err_sticky), 32'h0);
        check_eq("arst_rd_ready", 32'(acc_rd_ready), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_wr_valid", 32'(acc_wr_valid), 32'h0);
        check_eq("post_rst_can_read", 32'(accel_can_read), 32'h0);

        // Unmapped id.
        accel_id = 4'd7;
        #1;
        check_eq("unmap_can_read", 32'(accel_can_read), 32'h0);
        check_eq("unmap_can_write", 32'(accel_can_write), 32'h0);
        check_eq("unmap_rdata", 32'(accel_read_data), 32'h0);
        cpu_write(4'd7, 16'hDEAD, 1'b0);
        tick();
        check_eq("unmap_err", 32'(err_sticky), 32'h1);
        check_eq("unmap_no_push", 32'(acc_wr_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
